// File: rtl/mcycle_if.sv
// Request/response bundle between the control unit and the multi-cycle mul/div unit.
// Signal names follow the control unit's existing port names.
interface mcycle_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, done
    );
endinterface

// File: rtl/mcycle_unit.sv
// Unsigned shift-add multiplier / restoring divider, one bit per clock.
// Result2:Result1 = product, or remainder:quotient.
//
//   state     | meaning
//   IDLE      | waiting for Start; operands captured on the Start edge
//   COMPUTING | one iteration per clock, WIDTH iterations
//   DONE      | results valid, done pulse, back to IDLE next edge
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic     CLK,
    input  logic     rst,
    mcycle_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPUTING = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     op1;
    logic [WIDTH-1:0]     op2;
    logic                 op;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     result1_q;
    logic [WIDTH-1:0]     result2_q;
    logic                 done_q;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     trial;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   div_next;
    logic                 trial_unused;

    // Multiply: upper half accumulates, lower half holds the multiplier and
    // shifts out; the add carry becomes the new MSB after the right shift.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op1} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: the shifted remainder can exceed WIDTH bits, so the trial
    // subtract carries one extra bit and a borrow that signals "negative".
    assign rem_sh       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign trial        = {1'b0, rem_sh} - {2'b00, op2};
    assign q_bit        = ~trial[WIDTH+1];
    assign trial_unused = trial[WIDTH];
    assign div_next     = {(q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                           acc[WIDTH-2:0], q_bit};

    assign acc_next = op ? div_next : mul_next;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.Start) next_state = COMPUTING;
            COMPUTING: if (count == LAST) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            count     <= '0;
            op1       <= '0;
            op2       <= '0;
            op        <= 1'b0;
            acc       <= '0;
            result1_q <= '0;
            result2_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && bus.Start) begin
                op1   <= bus.Operand1;
                op2   <= bus.Operand2;
                op    <= bus.MCycleOp;
                count <= '0;
                acc   <= {{WIDTH{1'b0}}, (bus.MCycleOp ? bus.Operand1 : bus.Operand2)};
            end else if (state == COMPUTING) begin
                acc   <= acc_next;
                count <= count + 1'b1;
                if (count == LAST) begin
                    result1_q <= acc_next[WIDTH-1:0];
                    result2_q <= acc_next[2*WIDTH-1:WIDTH];
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;
    assign bus.done    = done_q;
    // Combinational on Start so the requester stalls in its issue cycle.
    assign bus.Busy    = ~rst & ((state == COMPUTING) | ((state == IDLE) & bus.Start));

endmodule

// File: tb/tb_mcycle_unit.sv
// Randomized and directed checks of mcycle_unit against an arithmetic reference model.
module tb_mcycle_unit;
    localparam int WIDTH = 32;

    logic CLK;
    logic rst;
    int   n_compared;
    int   n_mismatched;
    int   done_pulses;

    mcycle_if #(.WIDTH(WIDTH)) mif ();

    mcycle_unit #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (mif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mif.done === 1'b1) done_pulses++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {Result2, Result1} from plain arithmetic.
    function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (!op) begin
            r = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    // Waits up to 'limit' edges for done; returns the number of edges seen.
    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge CLK);
            edges++;
            #1;
            if (mif.done === 1'b1) break;
            if (edges == 16) check_val("busy_mid_compute", {63'd0, mif.Busy}, 64'd1);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int edges;
        int p0;
        exp = model(op, a, b);
        @(negedge CLK);
        mif.Start    = 1'b1;
        mif.MCycleOp = op;
        mif.Operand1 = a;
        mif.Operand2 = b;
        #1 check_val({tag, ".busy_issue"}, {63'd0, mif.Busy}, 64'd1);
        @(posedge CLK);
        #1 p0 = done_pulses;
        @(negedge CLK);
        mif.Start    = 1'b0;
        mif.MCycleOp = 1'($urandom);
        mif.Operand1 = $urandom;
        mif.Operand2 = $urandom;
        wait_done(100, edges);
        check_val({tag, ".latency"}, 64'(edges), 64'(WIDTH));
        check_val({tag, ".result"}, {mif.Result2, mif.Result1}, exp);
        check_val({tag, ".busy_done"}, {63'd0, mif.Busy}, 64'd0);
        @(posedge CLK);
        #1 check_val({tag, ".done_one_cycle"}, {63'd0, mif.done}, 64'd0);
        check_val({tag, ".result_hold"}, {mif.Result2, mif.Result1}, exp);
        check_val({tag, ".pulse_count"}, 64'(done_pulses - p0), 64'd1);
    endtask

    initial begin
        int edges;
        int p;
        logic        rop;
        logic [31:0] ra, rb;

        n_compared   = 0;
        n_mismatched = 0;
        done_pulses  = 0;
        rst          = 1'b1;
        mif.Start    = 1'b0;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = '0;
        mif.Operand2 = '0;

        repeat (2) @(negedge CLK);
        check_val("reset.results", {mif.Result2, mif.Result1}, 64'd0);
        check_val("reset.done", {63'd0, mif.done}, 64'd0);
        check_val("reset.busy", {63'd0, mif.Busy}, 64'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd7, 32'd6, "mul_7x6");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        run_op(1'b1, 32'd100, 32'd7, "div_100_7");
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, "div_max_1");
        run_op(1'b1, 32'd5, 32'd0, "div_by_zero");

        for (int i = 0; i < 16; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'($urandom_range(0, 65535));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, "random");
        end

        // Start held high across two operations; operands change mid-compute.
        @(negedge CLK);
        p = done_pulses;
        mif.Start    = 1'b1;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = 32'd3;
        mif.Operand2 = 32'd4;
        @(posedge CLK);
        repeat (5) @(negedge CLK);
        mif.MCycleOp = 1'b1;
        mif.Operand1 = 32'd9;
        mif.Operand2 = 32'd2;
        wait_done(100, edges);
        check_val("held.first_result", {mif.Result2, mif.Result1}, model(1'b0, 32'd3, 32'd4));
        @(posedge CLK);
        #1 check_val("held.idle_busy", {63'd0, mif.Busy}, 64'd1);
        check_val("held.idle_done", {63'd0, mif.done}, 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        mif.Start = 1'b0;
        wait_done(100, edges);
        check_val("held.second_latency", 64'(edges), 64'(WIDTH));
        check_val("held.second_result", {mif.Result2, mif.Result1}, model(1'b1, 32'd9, 32'd2));
        repeat (5) @(posedge CLK);
        #1 check_val("held.pulse_count", 64'(done_pulses - p), 64'd2);

        // Asynchronous reset in the middle of a multiply.
        @(negedge CLK);
        mif.Start    = 1'b1;
        mif.MCycleOp = 1'b0;
        mif.Operand1 = 32'h1234;
        mif.Operand2 = 32'h5678;
        @(posedge CLK);
        @(negedge CLK);
        mif.Start = 1'b0;
        repeat (10) @(posedge CLK);
        #2 rst = 1'b1;
        p = done_pulses;
        #1 check_val("rst.results", {mif.Result2, mif.Result1}, 64'd0);
        check_val("rst.done", {63'd0, mif.done}, 64'd0);
        check_val("rst.busy", {63'd0, mif.Busy}, 64'd0);
        @(negedge CLK);
        mif.Start = 1'b1;
        #1 check_val("rst.busy_with_start", {63'd0, mif.Busy}, 64'd0);
        mif.Start = 1'b0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        repeat (40) @(posedge CLK);
        #1 check_val("rst.no_done", 64'(done_pulses - p), 64'd0);
        check_val("rst.results_after", {mif.Result2, mif.Result1}, 64'd0);
        run_op(1'b0, 32'd2, 32'd3, "mul_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, observed overrun, expected completion");
        $fatal(1, "timeout");
    end

endmodule
